// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the fetch-side branch predictor.
package branch_predictor_pkg;

  // Two-bit saturating direction counter; bit 1 set means "predict taken".
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // Control part of a table entry; this is all that reset touches.
  typedef struct packed {
    logic valid;
    ctr_e ctr;
  } entry_ctl_t;

  localparam entry_ctl_t ENTRY_INIT = '{valid: 1'b0, ctr: WNT};

  // PCs are word aligned, so the index starts above the byte offset and
  // the tag sits directly above the index.
  localparam int PC_IDX_LSB   = 2;
  localparam int DEF_IDX_BITS = 4;
  localparam int DEF_TAG_BITS = 8;

  function automatic int tag_lsb(input int idx_bits);
    return PC_IDX_LSB + idx_bits;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Pipeline-facing signals of the branch predictor: IF lookup and ID resolve.
interface branch_predictor_if;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        stall;
  logic        ext_flush;
  logic        id_branch;
  logic        id_taken;
  logic [31:0] id_target;
  logic        mispredict;
  logic [31:0] redirect_pc;

  // Pipeline side: supplies fetch PC and resolved outcomes.
  modport master (
    output if_pc, stall, ext_flush, id_branch, id_taken, id_target,
    input  pred_taken, pred_target, mispredict, redirect_pc
  );

  // Predictor side.
  modport slave (
    input  if_pc, stall, ext_flush, id_branch, id_taken, id_target,
    output pred_taken, pred_target, mispredict, redirect_pc
  );
endinterface

// File: rtl/branch_predictor_bp_table.sv
// Direct-mapped history/target table: two combinational read ports
// (IF lookup, ID resolve) and one synchronous write port.
module bp_table
  import branch_predictor_pkg::*;
#(
  parameter int IDX_BITS = DEF_IDX_BITS,
  parameter int TAG_BITS = DEF_TAG_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] rd0_idx,
  input  logic [TAG_BITS-1:0] rd0_tag,
  output logic                rd0_hit,
  output ctr_e                rd0_ctr,
  output logic [31:0]         rd0_target,
  input  logic [IDX_BITS-1:0] rd1_idx,
  input  logic [TAG_BITS-1:0] rd1_tag,
  output logic                rd1_hit,
  output ctr_e                rd1_ctr,
  output logic [31:0]         rd1_target,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic                wr_valid,
  input  logic [TAG_BITS-1:0] wr_tag,
  input  logic [31:0]         wr_target,
  input  ctr_e                wr_ctr
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [ENTRIES-1:0]  valid_q, valid_d;
  ctr_e                ctr_q    [ENTRIES];
  ctr_e                ctr_d    [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_d    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [31:0]         target_d [ENTRIES];

  // Read ports observe the stored state only; a same-cycle write is not bypassed.
  always_comb begin
    rd0_hit    = valid_q[rd0_idx] && (tag_q[rd0_idx] == rd0_tag);
    rd0_ctr    = ctr_q[rd0_idx];
    rd0_target = target_q[rd0_idx];
    rd1_hit    = valid_q[rd1_idx] && (tag_q[rd1_idx] == rd1_tag);
    rd1_ctr    = ctr_q[rd1_idx];
    rd1_target = target_q[rd1_idx];
  end

  // Single write port: replace the whole addressed entry.
  always_comb begin
    valid_d  = valid_q;
    ctr_d    = ctr_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (wr_en) begin
      valid_d[wr_idx]  = wr_valid;
      ctr_d[wr_idx]    = wr_ctr;
      tag_d[wr_idx]    = wr_tag;
      target_d[wr_idx] = wr_target;
    end
  end

  // Valid bits and counters are control state and are cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= {ENTRIES{ENTRY_INIT.valid}};
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= ENTRY_INIT.ctr;
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  // Tags and targets are only meaningful behind a valid bit, so no reset.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: predicts in IF, carries the prediction into
// ID, checks it against the resolved outcome and trains the table.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_BITS = DEF_IDX_BITS,
  parameter int TAG_BITS = DEF_TAG_BITS
) (
  input  logic              clk,
  input  logic              reset,
  branch_predictor_if.slave bus
);

  localparam int TAG_LSB = tag_lsb(IDX_BITS);

  function automatic ctr_e ctr_sat_inc(input ctr_e c);
    return (c == ST) ? ST : ctr_e'(c + 2'd1);
  endfunction

  function automatic ctr_e ctr_sat_dec(input ctr_e c);
    return (c == SNT) ? SNT : ctr_e'(c - 2'd1);
  endfunction

  logic                r_valid_q, r_valid_d;
  logic [31:0]         r_pc_q, r_pc_d;
  logic                r_pred_taken_q, r_pred_taken_d;
  logic [31:0]         r_pred_target_q, r_pred_target_d;

  logic [IDX_BITS-1:0] if_idx, r_idx;
  logic [TAG_BITS-1:0] if_tag, r_tag;
  logic                if_hit, r_hit;
  ctr_e                if_ctr, r_ctr;
  logic [31:0]         if_target, r_target;

  logic                pred_taken;
  logic [31:0]         pred_target;
  logic                resolve;
  logic                mispredict;
  logic [31:0]         redirect_pc;

  logic                wr_en;
  logic                wr_valid;
  ctr_e                wr_ctr;
  logic [31:0]         wr_target;

  assign if_idx = bus.if_pc[PC_IDX_LSB +: IDX_BITS];
  assign if_tag = bus.if_pc[TAG_LSB +: TAG_BITS];
  assign r_idx  = r_pc_q[PC_IDX_LSB +: IDX_BITS];
  assign r_tag  = r_pc_q[TAG_LSB +: TAG_BITS];

  bp_table #(
    .IDX_BITS (IDX_BITS),
    .TAG_BITS (TAG_BITS)
  ) u_table (
    .clk        (clk),
    .reset      (reset),
    .rd0_idx    (if_idx),
    .rd0_tag    (if_tag),
    .rd0_hit    (if_hit),
    .rd0_ctr    (if_ctr),
    .rd0_target (if_target),
    .rd1_idx    (r_idx),
    .rd1_tag    (r_tag),
    .rd1_hit    (r_hit),
    .rd1_ctr    (r_ctr),
    .rd1_target (r_target),
    .wr_en      (wr_en),
    .wr_idx     (r_idx),
    .wr_valid   (wr_valid),
    .wr_tag     (r_tag),
    .wr_target  (wr_target),
    .wr_ctr     (wr_ctr)
  );

  // IF lookup: taken only on a tag hit with the counter in a taken state.
  always_comb begin
    pred_taken  = if_hit && if_ctr[1];
    pred_target = pred_taken ? if_target : bus.if_pc + 32'd4;
  end

  // ID resolution: a stalled or empty record never flags a mispredict.
  always_comb begin
    resolve    = r_valid_q && !bus.stall;
    mispredict = 1'b0;
    if (resolve) begin
      if (bus.id_branch) begin
        mispredict = (bus.id_taken != r_pred_taken_q) ||
                     (bus.id_taken && (bus.id_target != r_pred_target_q));
      end else if (r_pred_taken_q) begin
        mispredict = 1'b1;
      end
    end
    redirect_pc = (bus.id_branch && bus.id_taken) ? bus.id_target : r_pc_q + 32'd4;
  end

  // Table training, re-reading the entry at resolve time so back-to-back
  // resolutions of the same branch see each other's updates.
  always_comb begin
    wr_en     = 1'b0;
    wr_valid  = 1'b1;
    wr_ctr    = r_ctr;
    wr_target = r_target;
    if (resolve) begin
      if (bus.id_branch) begin
        if (r_hit) begin
          wr_en = 1'b1;
          if (bus.id_taken) begin
            wr_ctr    = ctr_sat_inc(r_ctr);
            wr_target = bus.id_target;
          end else begin
            wr_ctr = ctr_sat_dec(r_ctr);
          end
        end else if (bus.id_taken) begin
          wr_en     = 1'b1;
          wr_ctr    = WT;
          wr_target = bus.id_target;
        end
      end else if (r_pred_taken_q) begin
        // A non-branch matched this entry: drop it.
        wr_en    = 1'b1;
        wr_valid = 1'b0;
      end
    end
  end

  // IF/ID prediction record: flush beats stall beats capture.
  always_comb begin
    r_valid_d       = r_valid_q;
    r_pc_d          = r_pc_q;
    r_pred_taken_d  = r_pred_taken_q;
    r_pred_target_d = r_pred_target_q;
    if (bus.ext_flush || mispredict) begin
      r_valid_d = 1'b0;
    end else if (!bus.stall) begin
      r_valid_d       = 1'b1;
      r_pc_d          = bus.if_pc;
      r_pred_taken_d  = pred_taken;
      r_pred_target_d = pred_target;
    end
  end

  // Record registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid_q       <= 1'b0;
      r_pc_q          <= 32'd0;
      r_pred_taken_q  <= 1'b0;
      r_pred_target_q <= 32'd0;
    end else begin
      r_valid_q       <= r_valid_d;
      r_pc_q          <= r_pc_d;
      r_pred_taken_q  <= r_pred_taken_d;
      r_pred_target_q <= r_pred_target_d;
    end
  end

  assign bus.pred_taken  = pred_taken;
  assign bus.pred_target = pred_target;
  assign bus.mispredict  = mispredict;
  assign bus.redirect_pc = redirect_pc;

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side counterpart to the ID-stage branch resolver. It predicts direction and target for the PC being fetched in IF.
- It carries each prediction alongside the instruction into ID, then compares it with the resolved outcome (taken flag, target).
- On a wrong prediction it raises a flush and a redirect PC, and it trains a direct-mapped branch history/target table.
- Sits between the PC register, the IF/ID register and the ID-stage branch-decision logic of the 5-stage pipeline.

Parameters:
- IDX_BITS, 4, table index width; ENTRIES = 2**IDX_BITS, index = pc[IDX_BITS+1:2].
- TAG_BITS, 8, stored tag width; tag = pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2].

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- if_pc  in  32  PC currently in IF
- pred_taken  out  1  IF prediction: taken
- pred_target  out  32  IF predicted next PC (target if taken, else if_pc+4)
- stall  in  1  IF/ID hold (load-use etc.); ID branch not resolvable this cycle
- ext_flush  in  1  flush from a later stage (exception/jump); kills the IF/ID record
- id_branch  in  1  instruction in ID is a conditional branch
- id_taken  in  1  resolved direction (BranchHazard output)
- id_target  in  32  resolved branch target
- mispredict  out  1  flush IF/ID and load redirect_pc into PC
- redirect_pc  out  32  correct next PC

Behaviour:
- Table: ENTRIES entries of {valid, tag, target[31:0], ctr[1:0]}. Async reset clears all valid bits and sets ctr=01. No other table reset is needed.
- Lookup is combinational from the table state and if_pc.
  - hit = valid[idx] && tag match.
  - pred_taken = hit && ctr[1].
  - pred_target = pred_taken ? target : if_pc+4.
- ID record registers: r_valid, r_pc, r_pred_taken, r_pred_target. Reset sets all of them to 0.
  - Priority 1: reset.
  - Priority 2: if ext_flush or mispredict, r_valid <= 0.
  - Priority 3: if stall, hold.
  - Otherwise, capture {1, if_pc, pred_taken, pred_target}.
- Resolution (combinational), active only when r_valid && !stall:
  - Branch case: if id_branch, mispredict = (id_taken != r_pred_taken) || (id_taken && id_target != r_pred_target).
  - Alias case: if !id_branch && r_pred_taken, mispredict = 1 (a non-branch hit a stale entry).
  - Otherwise mispredict = 0.
- redirect_pc = (id_branch && id_taken) ? id_target : r_pc+4.
- Outputs at reset: pred_taken=0, pred_target=if_pc+4, mispredict=0, redirect_pc=4.
- Update (registered, same condition r_valid && !stall), applied at the next clk edge to the entry indexed by r_pc:
  - Branch, taken, hit: ctr saturating increment (11 stays 11); target <= id_target.
  - Branch, not taken, hit: ctr saturating decrement (00 stays 00).
  - Branch, taken, miss: allocate with valid=1, tag, target=id_target, ctr=10.
  - Branch, not taken, miss: no change (no allocation).
  - Alias case: valid <= 0.
- Exactly one update per resolved branch. Stalled cycles never update and never assert mispredict.
- Same-cycle update and lookup of the same index: the lookup sees the pre-update value, with no bypass.
- Flush with priority: when mispredict=1, the instruction fetched this cycle is discarded by r_valid <= 0. That same-cycle fetch must not be trained later.
- ext_flush together with a resolving branch: the resolution and update still occur, since the branch in ID is older. The record is then cleared.
- PC arithmetic is modulo 2^32; 0xFFFFFFFC+4 wraps to 0.
- Reset mid-operation: the table is invalidated and any in-flight record is dropped. Prediction after reset is always not-taken.

Decomposition:
- Shared package: counter encodings (SNT=00, WNT=01, WT=10, ST=11), the ENTRY_INIT constant, and the index/tag slice helpers/localparams.
- One sub-module, bp_table: storage array with a combinational read port and a synchronous single write port with async valid clear. Resolution and the record registers stay in the top module.

Test Plan:
- Reset, then if_pc=0x00400010 -> pred_taken=0, pred_target=0x00400014. Branch resolves taken to 0x00400000 -> mispredict=1, redirect_pc=0x00400000; the entry is allocated with ctr=10.
- Refetch 0x00400010 -> pred_taken=1, pred_target=0x00400000. Resolves taken to the same target -> mispredict=0, ctr=11. Then not-taken -> mispredict=1, redirect_pc=0x00400014, ctr=10.
- Branch in ID with stall=1 for 3 cycles, then stall=0 -> mispredict is asserted only in the unstalled cycle, and the ctr changes exactly once.
- Aliasing: PC 0x00400050 shares an index with 0x00400010 but has a different tag -> miss, pred_taken=0. A non-branch with the same index and tag as a trained entry -> mispredict=1, redirect=r_pc+4, entry invalidated.
- Taken hit but id_target differs (0x00400100 vs predicted 0x00400000) -> mispredict=1, redirect_pc=0x00400100, stored target updated.
- Assert reset while a mispredicting branch is in ID -> mispredict=0 immediately (async), all entries invalid, next lookup not-taken.
